dpram_arbiter: RTL and testbench

Two-requester access controller in front of the dual-port RAM block. Each requester issues reads and writes through a valid/grant handshake. The arbiter drives the RAM's cs/we/oe/address/data pins so that the RAM's two hazards never occur:
- two writes in the same cycle;
- a read while any write is active.

---
 rtl/dpram_arbiter_pkg.sv | 19 +
 rtl/dpram_arbiter_rr_arb2.sv | 35 +++
 rtl/dpram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dpram_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_arbiter_pkg
//  Description : Shared FSM state encoding and port indices for dpram_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dpram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD1  = 2'd1,
    ST_RD2  = 2'd2
  } state_e;

  localparam int unsigned C_PORT0 = 0;
  localparam int unsigned C_PORT1 = 1;

endpackage
`default_nettype wire

// File: rtl/dpram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter; `last` holds the port served.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    last_d = upd_en ? gnt[1] : last_q;
  end

  // last=1 after reset so port 0 wins the first conflict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dpram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_arbiter
//  Description : Two-requester access controller for a dual-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_cs0,
  output logic                  ram_we0,
  output logic                  ram_oe0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [DATA_WIDTH-1:0] ram_din0,
  input  logic [DATA_WIDTH-1:0] ram_dout0,
  output logic                  ram_cs1,
  output logic                  ram_we1,
  output logic                  ram_oe1,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  output logic [DATA_WIDTH-1:0] ram_din1,
  input  logic [DATA_WIDTH-1:0] ram_dout1
);

  logic [1:0]            req, wr, gnt, acc, rr_gnt;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [DATA_WIDTH-1:0] ram_dout  [2];
  logic                  idle, both_rd, upd_en;

  state_e                state_q, state_d;
  logic [1:0]            cs_q, cs_d, we_q, we_d, oe_q, oe_d, rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] addr_q  [2];
  logic [ADDR_WIDTH-1:0] addr_d  [2];
  logic [DATA_WIDTH-1:0] din_q   [2];
  logic [DATA_WIDTH-1:0] din_d   [2];
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];

  assign req          = {req1, req0};
  assign wr           = {wr1, wr0};
  assign req_addr[0]  = addr0;
  assign req_addr[1]  = addr1;
  assign req_wdata[0] = wdata0;
  assign req_wdata[1] = wdata1;
  assign ram_dout[0]  = ram_dout0;
  assign ram_dout[1]  = ram_dout1;

  // Two reads never collide, so they are served together and leave the pointer alone
  assign idle    = rst_n && (state_q == ST_IDLE);
  assign both_rd = (&req) && !(|wr);
  assign upd_en  = idle && (|req) && !both_rd;
  assign gnt     = idle ? (both_rd ? 2'b11 : rr_gnt) : 2'b00;
  assign acc     = req & gnt;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .upd_en (upd_en),
    .gnt    (rr_gnt)
  );

  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    we_d     = we_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    case (state_q)
      ST_IDLE: begin
        cs_d = 2'b00;
        we_d = 2'b00;
        oe_d = 2'b00;
        for (int n = 0; n < 2; n++) begin
          if (acc[n]) begin
            cs_d[n]   = 1'b1;
            addr_d[n] = req_addr[n];
            if (wr[n]) begin
              we_d[n]  = 1'b1;
              din_d[n] = req_wdata[n];
            end else begin
              oe_d[n]  = 1'b1;
            end
          end
        end
        if (|(acc & ~wr)) begin
          state_d = ST_RD1;
        end
      end
      ST_RD1: begin
        state_d = ST_RD2;
      end
      ST_RD2: begin
        // RAM output register was loaded one edge ago; capture it now
        for (int n = 0; n < 2; n++) begin
          if (oe_q[n]) begin
            rdata_d[n]  = ram_dout[n];
            rvalid_d[n] = 1'b1;
          end
        end
        cs_d    = 2'b00;
        oe_d    = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cs_q     <= 2'b00;
      we_q     <= 2'b00;
      oe_q     <= 2'b00;
      rvalid_q <= 2'b00;
      addr_q   <= '{default: '0};
      din_q    <= '{default: '0};
      rdata_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt0      = gnt[C_PORT0];
  assign gnt1      = gnt[C_PORT1];
  assign rvalid0   = rvalid_q[C_PORT0];
  assign rvalid1   = rvalid_q[C_PORT1];
  assign rdata0    = rdata_q[C_PORT0];
  assign rdata1    = rdata_q[C_PORT1];
  assign ram_cs0   = cs_q[C_PORT0];
  assign ram_cs1   = cs_q[C_PORT1];
  assign ram_we0   = we_q[C_PORT0];
  assign ram_we1   = we_q[C_PORT1];
  assign ram_oe0   = oe_q[C_PORT0];
  assign ram_oe1   = oe_q[C_PORT1];
  assign ram_addr0 = addr_q[C_PORT0];
  assign ram_addr1 = addr_q[C_PORT1];
  assign ram_din0  = din_q[C_PORT0];
  assign ram_din1  = din_q[C_PORT1];

endmodule
`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpram_arbiter
//  Description : Directed and random bench for dpram_arbiter with a RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] wr = 2'b00;
  logic [7:0] addr  [2] = '{8'h00, 8'h00};
  logic [7:0] wdata [2] = '{8'h00, 8'h00};
  logic [1:0] gnt, rvalid, ram_cs, ram_we, ram_oe;
  logic [7:0] rdata [2];
  logic [7:0] ram_addr [2];
  logic [7:0] ram_din  [2];
  logic [7:0] ram_dout [2];
  logic [7:0] dout_reg [2];
  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .wr0(wr[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .gnt0(gnt[0]), .rvalid0(rvalid[0]), .rdata0(rdata[0]),
    .req1(req[1]), .wr1(wr[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .gnt1(gnt[1]), .rvalid1(rvalid[1]), .rdata1(rdata[1]),
    .ram_cs0(ram_cs[0]), .ram_we0(ram_we[0]), .ram_oe0(ram_oe[0]),
    .ram_addr0(ram_addr[0]), .ram_din0(ram_din[0]), .ram_dout0(ram_dout[0]),
    .ram_cs1(ram_cs[1]), .ram_we1(ram_we[1]), .ram_oe1(ram_oe[1]),
    .ram_addr1(ram_addr[1]), .ram_din1(ram_din[1]), .ram_dout1(ram_dout[1])
  );

  // Dual-port RAM: synchronous write, registered output loaded under cs&oe
  assign ram_dout[0] = (ram_cs[0] && ram_oe[0]) ? dout_reg[0] : 8'hEE;
  assign ram_dout[1] = (ram_cs[1] && ram_oe[1]) ? dout_reg[1] : 8'hEE;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      for (int n = 0; n < 2; n++) begin
        if (ram_cs[n] && ram_we[n]) mem[ram_addr[n]] = ram_din[n];
        if (ram_cs[n] && ram_oe[n]) dout_reg[n] <= mem[ram_addr[n]];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard and hazard monitor, sampled mid-cycle
  initial begin
    logic [7:0] e;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    forever begin
      @(negedge clk);
      check_eq("no_dual_we", {31'd0, ram_we[0] & ram_we[1]}, 0);
      check_eq("no_rd_during_wr", {31'd0, (|ram_oe) & (|ram_we)}, 0);
      if (!rst_n) begin
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (req[n] && gnt[n]) begin
            if (wr[n]) shadow[addr[n]] = wdata[n];
            else if (n == 0) exp_q0.push_back(shadow[addr[n]]);
            else exp_q1.push_back(shadow[addr[n]]);
          end
        end
        if (rvalid[0]) begin
          if (exp_q0.size() == 0) check_eq("sb_spurious_rvalid0", 1, 0);
          else begin e = exp_q0.pop_front(); check_eq("sb_rdata0", {24'd0, rdata[0]}, {24'd0, e}); end
        end
        if (rvalid[1]) begin
          if (exp_q1.size() == 0) check_eq("sb_spurious_rvalid1", 1, 0);
          else begin e = exp_q1.pop_front(); check_eq("sb_rdata1", {24'd0, rdata[1]}, {24'd0, e}); end
        end
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b11;
    wr = 2'b11;
    edge1();
    @(negedge clk);
    check_eq("rst_gnt", {30'd0, gnt}, 0);
    check_eq("rst_ctrl", {26'd0, ram_cs, ram_we, ram_oe}, 0);
    check_eq("rst_rvalid", {30'd0, rvalid}, 0);
    check_eq("rst_rdata", {16'd0, rdata[1], rdata[0]}, 0);
    check_eq("rst_addr_din", {ram_addr[1], ram_addr[0], ram_din[1], ram_din[0]}, 0);
    edge1();
    req = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic do_write(input int p, input logic [7:0] a, input logic [7:0] d);
    req[p] = 1'b1; wr[p] = 1'b1; addr[p] = a; wdata[p] = d;
    @(negedge clk);
    check_eq("wr_gnt", {31'd0, gnt[p]}, 1);
    edge1();
    req[p] = 1'b0;
    @(negedge clk);
    check_eq("wr_ctrl", {29'd0, ram_cs[p], ram_we[p], ram_oe[p]}, 3'b110);
    check_eq("wr_addr_din", {16'd0, ram_addr[p], ram_din[p]}, {16'd0, a, d});
    edge1();
  endtask

  task automatic do_read(input int p, input logic [7:0] a, input logic [7:0] exp);
    req[p] = 1'b1; wr[p] = 1'b0; addr[p] = a;
    @(negedge clk);
    check_eq("rd_gnt", {31'd0, gnt[p]}, 1);
    edge1();
    req[p] = 1'b0;
    @(negedge clk);
    check_eq("rd1_ctrl", {29'd0, ram_cs[p], ram_we[p], ram_oe[p]}, 3'b101);
    edge1();
    @(negedge clk);
    check_eq("rd2_ctrl", {29'd0, ram_cs[p], ram_we[p], ram_oe[p]}, 3'b101);
    check_eq("rd2_no_rvalid", {31'd0, rvalid[p]}, 0);
    edge1();
    @(negedge clk);
    check_eq("rd_rvalid", {31'd0, rvalid[p]}, 1);
    check_eq("rd_rdata", {24'd0, rdata[p]}, {24'd0, exp});
    check_eq("rd_ctrl_off", {30'd0, ram_cs[p], ram_oe[p]}, 0);
    edge1();
    @(negedge clk);
    check_eq("rd_rvalid_pulse", {31'd0, rvalid[p]}, 0);
    edge1();
  endtask

  initial begin
    logic [1:0] acc;
    int issued;
    int cycles;

    // Write then cross-port read
    do_reset();
    do_write(0, 8'h10, 8'hA5);
    do_read(1, 8'h10, 8'hA5);

    // Simultaneous writes: port 0 first, port 1 next cycle
    do_reset();
    req = 2'b11; wr = 2'b11;
    addr[0] = 8'h20; wdata[0] = 8'h11; addr[1] = 8'h21; wdata[1] = 8'h22;
    @(negedge clk); check_eq("ww_first", {30'd0, gnt}, 2'b01);
    edge1(); req[0] = 1'b0;
    @(negedge clk); check_eq("ww_second", {30'd0, gnt}, 2'b10);
    check_eq("ww_we_a", {30'd0, ram_we}, 2'b01);
    edge1(); req[1] = 1'b0;
    @(negedge clk); check_eq("ww_we_b", {30'd0, ram_we}, 2'b10);
    edge1();

    // Dual read in one batch, then readback of the other written word
    req = 2'b11; wr = 2'b00; addr[0] = 8'h10; addr[1] = 8'h21;
    @(negedge clk); check_eq("rr_gnt_both", {30'd0, gnt}, 2'b11);
    edge1(); req = 2'b00;
    edge1(); edge1();
    @(negedge clk);
    check_eq("rr_rvalid_both", {30'd0, rvalid}, 2'b11);
    check_eq("rr_rdata", {16'd0, rdata[1], rdata[0]}, {16'd0, 8'h22, 8'hA5});
    edge1();
    do_read(0, 8'h20, 8'h11);

    // Read/write contention: winners 0, 1, 0
    do_reset();
    req = 2'b11; wr = 2'b10;
    addr[0] = 8'h10; addr[1] = 8'h30; wdata[1] = 8'h33;
    @(negedge clk); check_eq("rw_c1", {30'd0, gnt}, 2'b01);
    edge1(); addr[0] = 8'h21;
    @(negedge clk); check_eq("rw_rd1_nogrant", {30'd0, gnt}, 2'b00);
    edge1();
    @(negedge clk); check_eq("rw_rd2_nogrant", {30'd0, gnt}, 2'b00);
    edge1();
    @(negedge clk); check_eq("rw_c2", {30'd0, gnt}, 2'b10);
    check_eq("rw_c1_rdata", {23'd0, rvalid[0], rdata[0]}, {23'd0, 1'b1, 8'hA5});
    edge1(); addr[1] = 8'h31; wdata[1] = 8'h44;
    @(negedge clk); check_eq("rw_c3", {30'd0, gnt}, 2'b01);
    edge1(); req[0] = 1'b0;
    @(negedge clk); check_eq("rw_held", {30'd0, gnt}, 2'b00);
    edge1(); edge1();
    @(negedge clk); check_eq("rw_last_wr", {30'd0, gnt}, 2'b10);
    edge1(); req = 2'b00;
    edge1();

    // Reset during RD1 aborts the read
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 8'h10;
    @(negedge clk); check_eq("ab_gnt", {31'd0, gnt[0]}, 1);
    edge1(); req[0] = 1'b0; req[1] = 1'b1; wr[1] = 1'b1; rst_n = 1'b0;
    @(negedge clk); check_eq("ab_gnt_in_rst", {30'd0, gnt}, 0);
    edge1(); rst_n = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    check_eq("ab_ctrl", {26'd0, ram_cs, ram_we, ram_oe}, 0);
    check_eq("ab_rvalid_a", {30'd0, rvalid}, 0);
    edge1();
    @(negedge clk); check_eq("ab_rvalid_b", {30'd0, rvalid}, 0);
    edge1();
    req = 2'b11; wr = 2'b11;
    addr[0] = 8'h40; wdata[0] = 8'h55; addr[1] = 8'h41; wdata[1] = 8'h66;
    @(negedge clk); check_eq("ab_first_conflict", {30'd0, gnt}, 2'b01);
    edge1(); req[0] = 1'b0;
    @(negedge clk); check_eq("ab_second", {30'd0, gnt}, 2'b10);
    edge1(); req = 2'b00;
    edge1();

    // Random mix; the scoreboard checks every returned read
    issued = 0;
    cycles = 0;
    while ((issued < 1000 || req != 2'b00) && cycles < 20000) begin
      @(negedge clk);
      acc = req & gnt;
      edge1();
      cycles++;
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) req[n] = 1'b0;
        if (!req[n] && issued < 1000 && $urandom_range(0, 3) != 0) begin
          req[n]   = 1'b1;
          wr[n]    = 1'($urandom_range(0, 1));
          addr[n]  = 8'($urandom_range(0, 15));
          wdata[n] = 8'($urandom);
          issued++;
        end
      end
    end
    check_eq("rand_completed", {31'd0, cycles < 20000}, 1);
    repeat (5) edge1();
    check_eq("rand_q0_drained", exp_q0.size(), 0);
    check_eq("rand_q1_drained", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
